// File: rtl/if_id_pkg.sv
// if_id_pkg: shared types and constants for the IF/ID instruction queue.
// Holds the default pc/instruction widths, the NOP encoding presented
// when the queue is empty, and the {pc, instru} entry type.
package if_id_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] instru;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry FIFO of {pc, instruction} pairs between IF and ID.
// Every entry has an explicit valid state, derived from occupancy, so an
// all-zero instruction word is a legitimate instruction and never a bubble.
// A flush from EX empties the queue in one cycle. rdy_in low freezes all state.
// Optional macro IF_ID_BYPASS_EN: an empty queue forwards the IF inputs
// straight to ID in the same cycle (zero-latency path).
module if_id_queue
  import if_id_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = if_id_pkg::ADDR_W,
  parameter int INST_W = if_id_pkg::INST_W
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     flush_in,
  input  logic                     if_valid_in,
  input  logic [ADDR_W-1:0]        if_pc_in,
  input  logic [INST_W-1:0]        if_instru_in,
  output logic                     if_ready_out,
  input  logic                     id_ready_in,
  output logic                     id_valid_out,
  output logic [ADDR_W-1:0]        id_pc_out,
  output logic [INST_W-1:0]        id_instru_out,
  output logic [$clog2(DEPTH):0]   count_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // The storage uses the shared entry type, so the queue widths must match it.
  if (ADDR_W != if_id_pkg::ADDR_W || INST_W != if_id_pkg::INST_W) begin : g_width_check
    $error("if_id_queue: ADDR_W/INST_W must match if_id_pkg entry widths");
  end

  if_id_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic [CNT_W-1:0] count;

  logic         full;
  logic         empty;
  logic         enq_fire;
  logic         deq_fire;
  logic         bypass_take;
  if_id_entry_t head;

  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign head         = mem[rp];
  assign if_ready_out = !full;
  assign count_out    = count;

`ifdef IF_ID_BYPASS_EN
  logic bypass_act;
  assign bypass_act  = empty && if_valid_in && rdy_in && !flush_in && !rst_in;
  assign bypass_take = bypass_act && id_ready_in;

  // Present the stored head, or the live IF instruction when bypassing an empty queue.
  always_comb begin
    id_valid_out  = 1'b0;
    id_pc_out     = '0;
    id_instru_out = NOP_INSTR;
    if (!empty) begin
      id_valid_out  = 1'b1;
      id_pc_out     = head.pc;
      id_instru_out = head.instru;
    end else if (bypass_act) begin
      id_valid_out  = 1'b1;
      id_pc_out     = if_pc_in;
      id_instru_out = if_instru_in;
    end
  end
`else
  assign bypass_take = 1'b0;

  // Present the stored head; an empty queue shows pc 0 and a NOP.
  always_comb begin
    id_valid_out  = 1'b0;
    id_pc_out     = '0;
    id_instru_out = NOP_INSTR;
    if (!empty) begin
      id_valid_out  = 1'b1;
      id_pc_out     = head.pc;
      id_instru_out = head.instru;
    end
  end
`endif

  // A bypassed instruction consumed by ID is never written into the array.
  assign enq_fire = if_valid_in && if_ready_out && !bypass_take;
  assign deq_fire = !empty && id_ready_in;

  // Pointer and occupancy update: reset, then freeze, then flush, then handshakes.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        wp    <= '0;
        rp    <= '0;
        count <= '0;
      end else begin
        if (enq_fire) wp <= wp + 1'b1;
        if (deq_fire) rp <= rp + 1'b1;
        if (enq_fire && !deq_fire) count <= count + CNT_W'(1);
        else if (!enq_fire && deq_fire) count <= count - CNT_W'(1);
      end
    end
  end

  // Entry storage write; contents are deliberately left unreset.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && !flush_in && enq_fire) begin
      mem[wp] <= '{pc: if_pc_in, instru: if_instru_in};
    end
  end

endmodule
